gpio_ctrl: RTL
==============

# gpio_ctrl

DUT-side GPIO peripheral that drives and samples the GPIO pins. It is the device end of the pins that the testbench GPIO agent monitors and drives. It exposes a small register file over a valid/ready request bus, synchronises the input pins and latches rising and falling edges into sticky interrupt status bits. Its `gpio_out`/`gpio_oe` connect to the agent's monitored inputs, and its `gpio_in` connects to the agent's driven outputs.

## Interface
- `N_GPIO`, default 4, number of pins, legal range 1..32.

Ports:
- `clk` input 1: sole clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: register request present.
- `req_ready` output 1: request accepted when `req_valid && req_ready`.
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 3: register index 0..7.
- `req_wdata` input 32: write data.
- `rsp_valid` output 1: one-cycle pulse, the response to an accepted request.
- `rsp_rdata` output 32: read data, valid with `rsp_valid` (0 for writes).
- `gpio_out` output N_GPIO: pin output values.
- `gpio_oe` output N_GPIO: pin output enables.
- `gpio_in` input N_GPIO: asynchronous pin input values.
- `irq` output 1: level interrupt.

## Operation
- Register map, by `req_addr`:
  - 0 OUT: rw, drives `gpio_out`.
  - 1 OE: rw, drives `gpio_oe`.
  - 2 IN: ro, synchronised pin values; writes ignored.
  - 3 OUT_SET: wo, OUT |= wdata; reads 0.
  - 4 OUT_CLR: wo, OUT &= ~wdata; reads 0.
  - 5 RISE_EN: rw, per-pin rising-edge enable.
  - 6 FALL_EN: rw, per-pin falling-edge enable.
  - 7 STATUS: rw1c, sticky edge flags; writing 1 clears, writing 0 has no effect.
- Bits [31:N_GPIO] of every register read 0; those write-data bits are ignored.
- Input path:
  - Two-flop synchroniser `s1`→`s2`, then history flop `s3`.
  - IN reads `s2`.
  - Rising edge on pin i: `s2[i] & ~s3[i]`.
  - Falling edge on pin i: `~s2[i] & s3[i]`.
- STATUS[i] sets on (rise & RISE_EN[i]) | (fall & FALL_EN[i]).
- Set has priority over a same-cycle W1C clear of the same bit.
- Edge detection is suppressed while the 2-bit `prime` counter (reset 0) is below 3. The counter increments each cycle until it saturates at 3, so pins already high or low at reset release never produce status.
- Clearing an enable bit does not clear an already-set STATUS bit.
- `irq` = |STATUS, driven from registered state with no combinational path from the bus.
- Reset values: `req_ready`=0 while `rst` is high and 1 otherwise.
- Reset values: `rsp_valid`=0, `rsp_rdata`=0, `gpio_out`=0, `gpio_oe`=0, `irq`=0.
- Reset values: all registers, synchroniser flops and `prime` = 0.
- Reset asserted mid-transaction drops any pending response. No `rsp_valid` is issued for a request accepted in the cycle `rst` rises.

## Timing
- `req_ready` is high every cycle out of reset, so one request can be accepted per cycle back-to-back.
- Write accepted at edge k: the register updates at edge k. `gpio_out`/`gpio_oe` reflect it after edge k, a one-cycle write-to-pin latency measured from request presentation.
- Response: `rsp_valid` is high for exactly the cycle after acceptance, and `rsp_rdata` holds the register value as of acceptance (pre-write).
- Back-to-back read after write to the same register returns the new value.
- Pin change captured by `s1` at edge k:
  - IN shows it after edge k+1.
  - STATUS bit sets at edge k+2.
  - `irq` rises after edge k+2.
- A W1C write accepted at edge k clears at edge k; `irq` falls after edge k if no other bits remain set.

## Test plan
- Reset values: hold `rst`, drive `gpio_in`=4'hF → all outputs 0, `req_ready`=0. Release reset → read STATUS = 0 and IN = 4'hF; `irq` stays 0.
- Output control, with N_GPIO=4:
  - Write OUT=0xFFFF_FFF5 → `gpio_out`=4'h5, read back 0x5.
  - Write OUT_SET=0x2 → 4'h7.
  - Write OUT_CLR=0x4 → 4'h3.
  - Write OE=0xA → `gpio_oe`=4'hA.
- Input sync: `gpio_in` 0→4'h9 just before edge k → IN read accepted at edge k+1 returns 0; one accepted at edge k+2 returns 4'h9.
- Interrupts:
  - RISE_EN=0x1, FALL_EN=0x2; pulse pin0 high → STATUS=0x1, `irq`=1.
  - Drop pin1 1→0 → STATUS=0x3.
  - Write STATUS=0x1 → 0x2, `irq` stays 1.
  - Write STATUS=0x2 → `irq`=0.
- Simultaneous set/clear: W1C of bit0 accepted at the same edge pin0's enabled rising edge sets it → STATUS[0]=1.
- Back-to-back: four consecutive requests (write OUT=3, read OUT, write OE=1, read OE) → four `rsp_valid` pulses on consecutive cycles, read data 3 and 1.

Source files
------------

// File: rtl/gpio_ctrl.sv
// GPIO peripheral: register file on a valid/ready bus, output drive and enable,
// synchronised inputs, and sticky edge-status bits that raise a level interrupt.
module gpio_ctrl #(
  parameter int unsigned N_GPIO = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic [N_GPIO-1:0] gpio_out,
  output logic [N_GPIO-1:0] gpio_oe,
  input  logic [N_GPIO-1:0] gpio_in,
  output logic              irq
);

  localparam logic [2:0] AddrOut     = 3'd0;
  localparam logic [2:0] AddrOe      = 3'd1;
  localparam logic [2:0] AddrIn      = 3'd2;
  localparam logic [2:0] AddrOutSet  = 3'd3;
  localparam logic [2:0] AddrOutClr  = 3'd4;
  localparam logic [2:0] AddrRiseEn  = 3'd5;
  localparam logic [2:0] AddrFallEn  = 3'd6;
  localparam logic [2:0] AddrStatus  = 3'd7;

  logic [N_GPIO-1:0] out_q, oe_q, rise_en_q, fall_en_q, status_q;
  logic [N_GPIO-1:0] s1_q, s2_q, s3_q;
  logic [1:0]        prime_q;

  logic              accept;
  logic              wr_en;
  logic [N_GPIO-1:0] wmask;
  logic [N_GPIO-1:0] edge_set;
  logic [N_GPIO-1:0] w1c;
  logic [N_GPIO-1:0] status_d;
  logic [31:0]       rdata_d;
  logic              unused_wdata;

  assign req_ready = ~rst;
  assign accept    = req_valid & req_ready;
  assign wr_en     = accept & req_write;
  // Upper write-data bits are ignored by every register.
  assign wmask        = req_wdata[N_GPIO-1:0];
  assign unused_wdata = ^req_wdata;

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;
  assign irq      = |status_q;

  // Edge detection and status next-state; edges are masked until the history flop is primed.
  always_comb begin
    edge_set = '0;
    if (prime_q == 2'd3) begin
      edge_set = (s2_q & ~s3_q & rise_en_q) | (~s2_q & s3_q & fall_en_q);
    end
    w1c = '0;
    if (wr_en && (req_addr == AddrStatus)) begin
      w1c = wmask;
    end
    // A same-cycle edge wins over the clear.
    status_d = (status_q & ~w1c) | edge_set;
  end

  // Read mux: pre-write register value, zero-extended; writes and write-only registers return 0.
  always_comb begin
    rdata_d = '0;
    if (!req_write) begin
      case (req_addr)
        AddrOut:    rdata_d[N_GPIO-1:0] = out_q;
        AddrOe:     rdata_d[N_GPIO-1:0] = oe_q;
        AddrIn:     rdata_d[N_GPIO-1:0] = s2_q;
        AddrRiseEn: rdata_d[N_GPIO-1:0] = rise_en_q;
        AddrFallEn: rdata_d[N_GPIO-1:0] = fall_en_q;
        AddrStatus: rdata_d[N_GPIO-1:0] = status_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Register file writes and sticky status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      status_q <= status_d;
      if (wr_en) begin
        case (req_addr)
          AddrOut:    out_q     <= wmask;
          AddrOe:     oe_q      <= wmask;
          AddrOutSet: out_q     <= out_q | wmask;
          AddrOutClr: out_q     <= out_q & ~wmask;
          AddrRiseEn: rise_en_q <= wmask;
          AddrFallEn: fall_en_q <= wmask;
          default:    ;
        endcase
      end
    end
  end

  // Input synchroniser, edge history flop and priming counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      prime_q <= '0;
    end else begin
      s1_q <= gpio_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      if (prime_q != 2'd3) begin
        prime_q <= prime_q + 2'd1;
      end
    end
  end

  // One-cycle response pulse for each accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_rdata <= accept ? rdata_d : 32'd0;
    end
  end

endmodule
